// File: rtl/pipe_skid_reg.sv
// Two-entry pipeline register with a skid slot.
// Entry M drives the downstream port. Entry S catches one entry that arrives
// while M is stalled. Both handshake outputs come straight from flops, so
// out_ready and in_valid never reach in_ready or out_valid combinationally.
// flush and reset clear both entries and zero their payload, so a bubble
// downstream carries instruction 0.
module pipe_skid_reg #(
  parameter int DATA_WIDTH = 32,
  parameter int SB_WIDTH   = 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_pc,
  input  logic [DATA_WIDTH-1:0] in_pc_plus_4,
  input  logic [DATA_WIDTH-1:0] in_instruction,
  input  logic [SB_WIDTH-1:0]   in_sb,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_pc,
  output logic [DATA_WIDTH-1:0] out_pc_plus_4,
  output logic [DATA_WIDTH-1:0] out_instruction,
  output logic [SB_WIDTH-1:0]   out_sb,
  output logic [1:0]            count
);

  // One entry packed as {sb, instruction, pc_plus_4, pc}, from MSB down to LSB.
  localparam int ENTRY_WIDTH = 3 * DATA_WIDTH + SB_WIDTH;

  logic [ENTRY_WIDTH-1:0] in_entry;
  logic [ENTRY_WIDTH-1:0] m_data_reg, m_data_next;
  logic [ENTRY_WIDTH-1:0] s_data_reg, s_data_next;
  logic                   m_valid_reg, m_valid_next;
  logic                   s_valid_reg, s_valid_next;
  logic                   push;
  logic                   pop;

  assign in_entry = {in_sb, in_instruction, in_pc_plus_4, in_pc};

  // in_ready is !S.valid, so push never depends on out_ready.
  // S can only fill while M is full, so a push and a pop in the same cycle
  // always finds S empty.
  assign push = in_valid && !s_valid_reg;
  assign pop  = m_valid_reg && out_ready;

  // Next-state selection. flush beats every handshake event.
  always_comb begin
    m_valid_next = m_valid_reg;
    s_valid_next = s_valid_reg;
    m_data_next  = m_data_reg;
    s_data_next  = s_data_reg;
    if (flush) begin
      m_valid_next = 1'b0;
      s_valid_next = 1'b0;
      m_data_next  = '0;
      s_data_next  = '0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          // Arrival with no departure: fill M first, and spill into S only
          // when M is occupied.
          if (!m_valid_reg) begin
            m_valid_next = 1'b1;
            m_data_next  = in_entry;
          end else begin
            s_valid_next = 1'b1;
            s_data_next  = in_entry;
          end
        end
        2'b01: begin
          // Departure with no arrival: the older skid entry moves forward.
          // With no skid entry, M goes empty and keeps its payload on out_*.
          if (s_valid_reg) begin
            m_data_next  = s_data_reg;
            s_valid_next = 1'b0;
          end else begin
            m_valid_next = 1'b0;
          end
        end
        2'b11: begin
          // Streaming case: replace M directly. S is already empty.
          m_data_next = in_entry;
        end
        default: begin
          // Stall: every register keeps its value.
        end
      endcase
    end
  end

  // State registers. Reset clears them asynchronously.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_valid_reg <= 1'b0;
      s_valid_reg <= 1'b0;
      m_data_reg  <= '0;
      s_data_reg  <= '0;
    end else begin
      m_valid_reg <= m_valid_next;
      s_valid_reg <= s_valid_next;
      m_data_reg  <= m_data_next;
      s_data_reg  <= s_data_next;
    end
  end

  assign out_valid       = m_valid_reg;
  assign in_ready        = !s_valid_reg;
  assign out_pc          = m_data_reg[DATA_WIDTH-1:0];
  assign out_pc_plus_4   = m_data_reg[2*DATA_WIDTH-1:DATA_WIDTH];
  assign out_instruction = m_data_reg[3*DATA_WIDTH-1:2*DATA_WIDTH];
  assign out_sb          = m_data_reg[ENTRY_WIDTH-1:3*DATA_WIDTH];
  assign count           = {1'b0, m_valid_reg} + {1'b0, s_valid_reg};

`ifndef SYNTHESIS
  // Structural invariant: the skid slot is never occupied while M is empty.
  a_skid_implies_main: assert property (
    @(posedge clk) disable iff (!rstn) s_valid_reg |-> m_valid_reg);
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Testbench for pipe_skid_reg.
// A bounded FIFO model (capacity 2) predicts every output at each falling edge.
// The directed scenarios also check the key points against literal values.
module tb_pipe_skid_reg;

  localparam int DW = 32;
  localparam int SW = 2;

  typedef struct packed {
    logic [SW-1:0] sb;
    logic [DW-1:0] instr;
    logic [DW-1:0] pc4;
    logic [DW-1:0] pc;
  } entry_t;

  logic          clk = 1'b0;
  logic          rstn;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_pc;
  logic [DW-1:0] in_pc_plus_4;
  logic [DW-1:0] in_instruction;
  logic [SW-1:0] in_sb;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_pc;
  logic [DW-1:0] out_pc_plus_4;
  logic [DW-1:0] out_instruction;
  logic [SW-1:0] out_sb;
  logic [1:0]    count;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  // q holds the entries in arrival order.
  // held is what out_* shows while q is empty.
  entry_t q[$];
  entry_t held;

  pipe_skid_reg #(.DATA_WIDTH(DW), .SB_WIDTH(SW)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_pc          (in_pc),
    .in_pc_plus_4   (in_pc_plus_4),
    .in_instruction (in_instruction),
    .in_sb          (in_sb),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_pc_plus_4  (out_pc_plus_4),
    .out_instruction(out_instruction),
    .out_sb         (out_sb),
    .count          (count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    held = '0;
  endtask

  // One clock edge of the model, using the handshake rules.
  task automatic model_step(input logic v, input logic r, input logic f, input entry_t e);
    bit do_push;
    bit do_pop;
    if (f) begin
      model_reset();
    end else begin
      do_push = v && (q.size() < 2);
      do_pop  = r && (q.size() > 0);
      if (do_pop) held = q.pop_front();
      if (do_push) q.push_back(e);
    end
  endtask

  task automatic compare_all();
    entry_t head;
    head = (q.size() > 0) ? q[0] : held;
    check_eq("out_valid", 64'(out_valid), 64'(q.size() > 0));
    check_eq("in_ready", 64'(in_ready), 64'(q.size() < 2));
    check_eq("count", 64'(count), 64'(q.size()));
    check_eq("out_pc", 64'(out_pc), 64'(head.pc));
    check_eq("out_pc_plus_4", 64'(out_pc_plus_4), 64'(head.pc4));
    check_eq("out_instruction", 64'(out_instruction), 64'(head.instr));
    check_eq("out_sb", 64'(out_sb), 64'(head.sb));
  endtask

  // Drive inputs at the falling edge, step the model at the rising edge,
  // then compare at the next falling edge.
  task automatic cycle(input logic v, input logic r, input logic f, input entry_t e);
    in_valid       = v;
    out_ready      = r;
    flush          = f;
    in_pc          = e.pc;
    in_pc_plus_4   = e.pc4;
    in_instruction = e.instr;
    in_sb          = e.sb;
    @(posedge clk);
    model_step(v, r, f, e);
    @(negedge clk);
    compare_all();
  endtask

  function automatic entry_t mk(input logic [DW-1:0] pc);
    entry_t e;
    e.pc    = pc;
    e.pc4   = pc + 32'd4;
    e.instr = pc ^ 32'hA5A5_0013;
    e.sb    = pc[3:2];
    return e;
  endfunction

  function automatic entry_t rand_entry();
    entry_t e;
    e.pc    = $urandom;
    e.pc4   = $urandom;
    e.instr = $urandom;
    e.sb    = SW'($urandom);
    return e;
  endfunction

  initial begin
    entry_t z;
    z              = '0;
    rstn           = 1'b0;
    flush          = 1'b0;
    in_valid       = 1'b0;
    out_ready      = 1'b0;
    in_pc          = '0;
    in_pc_plus_4   = '0;
    in_instruction = '0;
    in_sb          = '0;
    model_reset();

    // Values while reset is held.
    @(negedge clk);
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);
    check_eq("rst_count", 64'(count), 64'd0);
    check_eq("rst_instr", 64'(out_instruction), 64'd0);
    rstn = 1'b1;

    // Pass-through: three back-to-back pushes with out_ready high.
    cycle(1'b1, 1'b1, 1'b0, mk(32'h100));
    check_eq("pt_pc0", 64'(out_pc), 64'h100);
    check_eq("pt_rdy0", 64'(in_ready), 64'd1);
    cycle(1'b1, 1'b1, 1'b0, mk(32'h104));
    check_eq("pt_pc1", 64'(out_pc), 64'h104);
    check_eq("pt_rdy1", 64'(in_ready), 64'd1);
    cycle(1'b1, 1'b1, 1'b0, mk(32'h108));
    check_eq("pt_pc2", 64'(out_pc), 64'h108);
    check_eq("pt_vld2", 64'(out_valid), 64'd1);
    cycle(1'b0, 1'b1, 1'b0, z);
    check_eq("pt_empty", 64'(out_valid), 64'd0);
    check_eq("pt_hold_pc", 64'(out_pc), 64'h108);

    // Stall fill: two pushes with out_ready low. A third offer is refused.
    cycle(1'b1, 1'b0, 1'b0, mk(32'h200));
    cycle(1'b1, 1'b0, 1'b0, mk(32'h204));
    check_eq("sf_count", 64'(count), 64'd2);
    check_eq("sf_rdy", 64'(in_ready), 64'd0);
    check_eq("sf_pc", 64'(out_pc), 64'h200);
    cycle(1'b1, 1'b0, 1'b0, mk(32'h208));
    check_eq("sf_refuse_cnt", 64'(count), 64'd2);
    check_eq("sf_refuse_pc", 64'(out_pc), 64'h200);

    // Drain: two cycles with out_ready high and no new input.
    cycle(1'b0, 1'b1, 1'b0, z);
    check_eq("dr_pc1", 64'(out_pc), 64'h204);
    check_eq("dr_cnt1", 64'(count), 64'd1);
    check_eq("dr_rdy1", 64'(in_ready), 64'd1);
    cycle(1'b0, 1'b1, 1'b0, z);
    check_eq("dr_cnt0", 64'(count), 64'd0);
    check_eq("dr_vld0", 64'(out_valid), 64'd0);

    // Flush while full, with an input offered in the same cycle.
    cycle(1'b1, 1'b0, 1'b0, mk(32'h300));
    cycle(1'b1, 1'b0, 1'b0, mk(32'h304));
    cycle(1'b1, 1'b1, 1'b1, mk(32'h308));
    check_eq("fl_count", 64'(count), 64'd0);
    check_eq("fl_vld", 64'(out_valid), 64'd0);
    check_eq("fl_instr", 64'(out_instruction), 64'd0);
    check_eq("fl_rdy", 64'(in_ready), 64'd1);
    cycle(1'b0, 1'b1, 1'b0, z);
    check_eq("fl_no_ghost", 64'(out_valid), 64'd0);

    // Asynchronous reset asserted between clock edges while count = 1.
    cycle(1'b1, 1'b0, 1'b0, mk(32'h400));
    check_eq("ar_pre_cnt", 64'(count), 64'd1);
    in_valid = 1'b0;
    #2 rstn = 1'b0;
    #1;
    check_eq("ar_vld", 64'(out_valid), 64'd0);
    check_eq("ar_cnt", 64'(count), 64'd0);
    check_eq("ar_rdy", 64'(in_ready), 64'd1);
    check_eq("ar_pc", 64'(out_pc), 64'd0);
    model_reset();
    @(posedge clk);
    #2 rstn = 1'b1;
    @(negedge clk);
    compare_all();
    cycle(1'b1, 1'b0, 1'b0, mk(32'h500));
    check_eq("ar_first_push", 64'(out_pc), 64'h500);
    check_eq("ar_first_cnt", 64'(count), 64'd1);
    cycle(1'b0, 1'b1, 1'b0, z);

    // Random traffic checked against the model on every cycle.
    for (int i = 0; i < 10000; i++) begin
      cycle(1'($urandom_range(99, 0) < 60),
            1'($urandom_range(99, 0) < 55),
            1'($urandom_range(99, 0) < 3),
            rand_entry());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
